// File: rtl/chronometer_pkg.sv
// Shared types and default constants for the chronometer run/stop/lap/clear controller.
package chronometer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam int DEF_TICK_DIV   = 100000;
  localparam int DEF_DEB_CYCLES = 16;

  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted press (0->1 of the clean level).
module button_debounce
  import chronometer_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  // A differing sample streak of DEB_CYCLES flips the level; any agreeing sample restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/chronometer_ctrl.sv
// Chronometer controller: debounced buttons drive a four-state FSM that gates
// the BCD counter with a prescaled tick, issues clears and freezes lap values.
module chronometer_ctrl
  import chronometer_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic [15:0] count_in,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        frozen
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic          start_ev;
  logic          lap_ev;
  logic          clear_ev;
  state_t        state;
  state_t        next_state;
  logic          clr_req;
  logic          lap_take;
  logic [PW-1:0] presc;
  logic [15:0]   lap_reg;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk   (CLK),
    .rst_n (RST),
    .raw   (btn_start_stop),
    .press (start_ev)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk   (CLK),
    .rst_n (RST),
    .raw   (btn_lap),
    .press (lap_ev)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk   (CLK),
    .rst_n (RST),
    .raw   (btn_clear),
    .press (clear_ev)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state; clear > start > lap, and an event the state ignores falls through.
  always_comb begin
    next_state = state;
    clr_req    = 1'b0;
    lap_take   = 1'b0;
    case (state)
      IDLE: begin
        if (clear_ev) clr_req = 1'b1;
        else if (start_ev) next_state = RUN;
        else next_state = IDLE;
      end
      RUN: begin
        if (start_ev) begin
          next_state = PAUSE;
        end else if (lap_ev) begin
          next_state = LAP;
          lap_take   = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      LAP: begin
        if (start_ev) next_state = PAUSE;
        else if (lap_ev) next_state = RUN;
        else next_state = LAP;
      end
      PAUSE: begin
        if (clear_ev) begin
          next_state = IDLE;
          clr_req    = 1'b1;
        end else if (start_ev) begin
          next_state = RUN;
        end else begin
          next_state = PAUSE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Prescaler, lap latch and registered pulses. A wrap on the edge that leaves
  // the counting states is held at the top so resume ticks at once instead of losing it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc   <= '0;
      lap_reg <= 16'h0000;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else begin
      cnt_clr <= clr_req;
      running <= is_counting(next_state);
      frozen  <= (next_state == LAP);
      cnt_en  <= is_counting(state) && is_counting(next_state) && (presc == PRESC_MAX);
      if (lap_take) lap_reg <= count_in;
      else lap_reg <= lap_reg;
      if ((state == IDLE) || clr_req) presc <= '0;
      else if (!is_counting(state)) presc <= presc;
      else if (presc != PRESC_MAX) presc <= presc + PW'(1);
      else if (is_counting(next_state)) presc <= '0;
      else presc <= presc;
    end
  end

  // Display mux: frozen lap value or the live count.
  always_comb begin
    disp_bcd = count_in;
    if (frozen) disp_bcd = lap_reg;
    else disp_bcd = count_in;
  end

endmodule

// File: tb/tb_chronometer_ctrl.sv
// Bench for chronometer_ctrl (TICK_DIV=4, DEB_CYCLES=3): expected event cycles and
// values are queued when a button is driven and popped when the controller reacts.
`timescale 1ns/1ps
module tb_chronometer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int LAT      = DEB + 4;  // drive cycle to first cycle in the new state

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] count_in = 16'h0000;
  logic        cnt_en, cnt_clr, running, frozen;
  logic [15:0] disp_bcd;
  logic        load_req = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        hold = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_q[$];

  chronometer_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .count_in       (count_in),
    .cnt_en         (cnt_en),
    .cnt_clr        (cnt_clr),
    .disp_bcd       (disp_bcd),
    .running        (running),
    .frozen         (frozen)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int d = 0; d < 4; d++) begin
      if (r[d*4 +: 4] == 4'd9) begin
        r[d*4 +: 4] = 4'd0;
      end else begin
        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
        break;
      end
    end
    return r;
  endfunction

  // Stand-in for the counter datapath fed by cnt_en / cnt_clr.
  always @(posedge CLK) begin
    if (load_req) count_in <= load_val;
    else if (cnt_clr) count_in <= 16'h0000;
    else if (cnt_en && !hold) count_in <= bcd_inc(count_in);
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(input logic [15:0] v);
    load_val = v;
    load_req = 1'b1;
    step(1);
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    logic [15:0] v;
    RST = 1'b0;
    step(2);
    RST = 1'b1;
    for (int i = 0; i < 50; i++) begin
      v = 16'($urandom);
      exp_q.push_back(0);
      exp_q.push_back(int'(v));
      load(v);
      e = exp_q.pop_front();
      n_checks++;
      if ({cnt_en, cnt_clr, running, frozen} !== 4'(e)) begin
        n_fail++;
        $display("FAIL reset_flags: en/clr/run/frz=%b expected %b", {cnt_en, cnt_clr, running, frozen}, 4'(e));
      end
      e = exp_q.pop_front();
      n_checks++;
      if (disp_bcd !== 16'(e)) begin
        n_fail++;
        $display("FAIL reset_disp: disp_bcd=%h expected %h", disp_bcd, 16'(e));
      end
    end
  endtask

  task automatic test_start();
    int t0, rise, n_en, e;
    t0 = cyc;
    rise = -1;
    n_en = 0;
    btn_start_stop = 1'b1;
    exp_q.push_back(t0 + LAT);
    for (int k = 1; k <= 3; k++) exp_q.push_back(t0 + LAT + k * TICK_DIV);
    for (int i = 0; i < 40 && n_en < 3; i++) begin
      step(1);
      if (cyc - t0 >= 10) btn_start_stop = 1'b0;
      if (running && rise < 0) begin
        rise = cyc;
        e = exp_q.pop_front();
        n_checks++;
        if (rise !== e) begin
          n_fail++;
          $display("FAIL start_rise: running rose %0d cycles after press, expected %0d", rise - t0, e - t0);
        end
      end
      if (cnt_en) begin
        n_en++;
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e) begin
          n_fail++;
          $display("FAIL start_tick: cnt_en at +%0d, expected +%0d", cyc - t0, e - t0);
        end
      end
    end
    btn_start_stop = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL start_timeout: event due at +%0d never seen", e - t0);
    end
    // 2-cycle glitch must not be accepted
    step(8);
    btn_start_stop = 1'b1;
    step(2);
    btn_start_stop = 1'b0;
    exp_q.push_back(1);
    step(10);
    e = exp_q.pop_front();
    n_checks++;
    if (running !== 1'(e) || frozen !== 1'b0) begin
      n_fail++;
      $display("FAIL start_glitch: running=%b frozen=%b expected running=%0d frozen=0", running, frozen, e);
    end
  endtask

  task automatic test_lap();
    int t0, e, seen;
    hold = 1'b1;
    load(16'h0123);
    t0 = cyc;
    seen = -1;
    btn_lap = 1'b1;
    exp_q.push_back(t0 + LAT);
    exp_q.push_back(16'h0123);
    for (int i = 0; i < 20 && seen < 0; i++) begin
      step(1);
      if (frozen) seen = cyc;
    end
    btn_lap = 1'b0;
    hold = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (seen !== e) begin
      n_fail++;
      $display("FAIL lap_enter: frozen at +%0d, expected +%0d", seen - t0, e - t0);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (disp_bcd !== 16'(e)) begin
      n_fail++;
      $display("FAIL lap_capture: disp_bcd=%h expected %h", disp_bcd, 16'(e));
    end
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(16'h0123);
      step(1);
      e = exp_q.pop_front();
      n_checks++;
      if (disp_bcd !== 16'(e) || frozen !== 1'b1) begin
        n_fail++;
        $display("FAIL lap_hold: disp_bcd=%h frozen=%b expected %h frozen=1", disp_bcd, frozen, 16'(e));
      end
    end
    t0 = cyc;
    seen = -1;
    btn_lap = 1'b1;
    exp_q.push_back(t0 + LAT);
    for (int i = 0; i < 20 && seen < 0; i++) begin
      step(1);
      if (!frozen) seen = cyc;
    end
    btn_lap = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (seen !== e) begin
      n_fail++;
      $display("FAIL lap_exit: unfrozen at +%0d, expected +%0d", seen - t0, e - t0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1);
      exp_q.push_back(int'(count_in));
      e = exp_q.pop_front();
      n_checks++;
      if (disp_bcd !== 16'(e) || running !== 1'b1) begin
        n_fail++;
        $display("FAIL lap_live: disp_bcd=%h running=%b expected %h running=1", disp_bcd, running, 16'(e));
      end
    end
    step(6);
  endtask

  task automatic test_pause_resume();
    int t0, t1, e, seen, rise, n_bad;
    seen = -1;
    for (int i = 0; i < 2 * TICK_DIV + 2 && seen < 0; i++) begin
      step(1);
      if (cnt_en) seen = cyc;
    end
    n_checks++;
    if (seen < 0) begin
      n_fail++;
      $display("FAIL pause_align: no cnt_en within %0d cycles, expected one", 2 * TICK_DIV + 2);
    end
    // pressed right after a wrap so the pause edge lands on prescaler value 2
    t0 = cyc;
    seen = -1;
    btn_start_stop = 1'b1;
    exp_q.push_back(t0 + LAT);
    for (int i = 0; i < 20 && seen < 0; i++) begin
      step(1);
      if (!running) seen = cyc;
    end
    btn_start_stop = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (seen !== e) begin
      n_fail++;
      $display("FAIL pause_enter: running fell at +%0d, expected +%0d", seen - t0, e - t0);
    end
    exp_q.push_back(0);
    n_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (cnt_en || running) n_bad++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (n_bad !== e) begin
      n_fail++;
      $display("FAIL pause_quiet: %0d cycles with cnt_en/running in pause, expected %0d", n_bad, e);
    end
    t1 = cyc;
    rise = -1;
    seen = -1;
    btn_start_stop = 1'b1;
    exp_q.push_back(t1 + LAT);
    exp_q.push_back(t1 + LAT + 1);
    for (int i = 0; i < 30 && seen < 0; i++) begin
      step(1);
      if (running && rise < 0) rise = cyc;
      if (cnt_en) seen = cyc;
    end
    btn_start_stop = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (rise !== e) begin
      n_fail++;
      $display("FAIL resume_rise: running rose at +%0d, expected +%0d", rise - t1, e - t1);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (seen !== e) begin
      n_fail++;
      $display("FAIL resume_tick: first cnt_en at +%0d, expected +%0d", seen - t1, e - t1);
    end
    step(8);
  endtask

  task automatic test_clear();
    int t0, e, seen, n_en, n_clr, n_run, clr_at;
    exp_q.push_back(0);
    exp_q.push_back(20 / TICK_DIV);
    exp_q.push_back(20);
    n_en = 0;
    n_clr = 0;
    n_run = 0;
    btn_clear = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i == 8) btn_clear = 1'b0;
      if (cnt_en) n_en++;
      if (cnt_clr) n_clr++;
      if (running) n_run++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (n_clr !== e) begin
      n_fail++;
      $display("FAIL clear_run_clr: %0d cnt_clr pulses in RUN, expected %0d", n_clr, e);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (n_en !== e) begin
      n_fail++;
      $display("FAIL clear_run_ticks: %0d cnt_en pulses in 20 cycles, expected %0d", n_en, e);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (n_run !== e) begin
      n_fail++;
      $display("FAIL clear_run_state: running for %0d of 20 cycles, expected %0d", n_run, e);
    end
    seen = -1;
    btn_start_stop = 1'b1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      step(1);
      if (!running) seen = cyc;
    end
    btn_start_stop = 1'b0;
    n_checks++;
    if (seen < 0) begin
      n_fail++;
      $display("FAIL clear_pause: running still 1 after start press, expected 0");
    end
    step(8);
    // s=0: start+clear together in PAUSE; s=1: clear alone in IDLE
    for (int s = 0; s < 2; s++) begin
      t0 = cyc;
      btn_clear = 1'b1;
      btn_start_stop = (s == 0);
      exp_q.push_back(t0 + LAT);
      exp_q.push_back(1);
      exp_q.push_back(0);
      n_clr = 0;
      n_run = 0;
      clr_at = -1;
      for (int i = 0; i < 20; i++) begin
        step(1);
        if (i == 8) begin
          btn_clear = 1'b0;
          btn_start_stop = 1'b0;
        end
        if (cnt_clr) begin
          n_clr++;
          if (clr_at < 0) clr_at = cyc;
        end
        if (running) n_run++;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (clr_at !== e) begin
        n_fail++;
        $display("FAIL clear_at_%0d: cnt_clr at +%0d, expected +%0d", s, clr_at - t0, e - t0);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (n_clr !== e) begin
        n_fail++;
        $display("FAIL clear_width_%0d: cnt_clr high %0d cycles, expected %0d", s, n_clr, e);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (n_run !== e) begin
        n_fail++;
        $display("FAIL clear_norun_%0d: running for %0d cycles, expected %0d", s, n_run, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int r, e, seen, rise;
    hold = 1'b1;
    load(16'h0456);
    btn_start_stop = 1'b1;
    step(LAT + 1);
    btn_start_stop = 1'b0;
    step(8);
    btn_lap = 1'b1;
    step(LAT + 1);
    btn_lap = 1'b0;
    step(8);
    exp_q.push_back(16'h0456);
    e = exp_q.pop_front();
    n_checks++;
    if (disp_bcd !== 16'(e) || frozen !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_lap: disp_bcd=%h frozen=%b expected %h frozen=1", disp_bcd, frozen, 16'(e));
    end
    btn_start_stop = 1'b1;
    step(3);
    RST = 1'b0;
    step(1);
    RST = 1'b1;
    r = cyc;
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(int'(count_in));
    e = exp_q.pop_front();
    n_checks++;
    if ({cnt_en, cnt_clr, running, frozen} !== 4'(e)) begin
      n_fail++;
      $display("FAIL rstmid_flags: en/clr/run/frz=%b expected %b", {cnt_en, cnt_clr, running, frozen}, 4'(e));
    end
    e = exp_q.pop_front();
    n_checks++;
    if (dut.lap_reg !== 16'(e)) begin
      n_fail++;
      $display("FAIL rstmid_lapreg: lap_reg=%h expected %h", dut.lap_reg, 16'(e));
    end
    e = exp_q.pop_front();
    n_checks++;
    if (disp_bcd !== 16'(e)) begin
      n_fail++;
      $display("FAIL rstmid_disp: disp_bcd=%h expected %h", disp_bcd, 16'(e));
    end
    hold = 1'b0;
    exp_q.push_back(r + LAT);
    exp_q.push_back(r + LAT + TICK_DIV);
    rise = -1;
    seen = -1;
    for (int i = 0; i < 30 && seen < 0; i++) begin
      step(1);
      if (running && rise < 0) rise = cyc;
      if (cnt_en) seen = cyc;
    end
    btn_start_stop = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (rise !== e) begin
      n_fail++;
      $display("FAIL rstmid_rise: running rose at +%0d after reset, expected +%0d", rise - r, e - r);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (seen !== e) begin
      n_fail++;
      $display("FAIL rstmid_tick: first cnt_en at +%0d after reset, expected +%0d", seen - r, e - r);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_resume();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/chronometer_ctrl.md
# chronometer_ctrl

Run/stop/lap/clear controller for the four-digit BCD chronometer. It takes three raw push-button inputs, debounces them, and runs a four-state FSM. It gates the counter datapath with a prescaled one-cycle tick and issues its clear pulse. It also latches the live BCD count for lap display, so the seven-segment decoders show either the live count or a frozen lap value.

## Interface
Parameters:
- TICK_DIV, 100000: CLK cycles per count tick; legal range ≥ 2.
- DEB_CYCLES, 16: consecutive stable synchronized samples required before a button level is accepted; legal range ≥ 1.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  one clock; reset is synchronous and active-low.
- btn_start_stop  in  1  raw asynchronous button level, active-high.
- btn_lap  in  1  raw asynchronous button level, active-high.
- btn_clear  in  1  raw asynchronous button level, active-high.
- count_in  in  16  live BCD count from the counter datapath, digit 0 in [3:0] through digit 3 in [15:12].
- cnt_en  out  1  one-cycle pulse; the counter advances by one on it.
- cnt_clr  out  1  one-cycle pulse; the counter zeroes on it.
- disp_bcd  out  16  value sent to the seven-segment decoders: lap_reg when frozen, otherwise count_in (combinational mux).
- running  out  1  high in RUN and LAP.
- frozen  out  1  high in LAP.

## Operation
- Button path:
  - Each button goes through a 2-flop synchronizer, then a stability counter.
  - The debounced level changes only after DEB_CYCLES consecutive equal synchronized samples that differ from the current level.
  - A press event is a registered one-cycle pulse on the debounced 0→1 transition. Releases generate nothing.
- FSM states: IDLE, RUN, PAUSE, LAP. Reset state is IDLE.
  - IDLE: start → RUN (prescaler zeroed); clear → cnt_clr pulse, stay in IDLE; lap ignored.
  - RUN: start → PAUSE; lap → LAP and lap_reg ← count_in on the transition cycle; clear ignored.
  - LAP: lap → RUN (display goes live); start → PAUSE (display goes live); clear ignored.
  - PAUSE: start → RUN; clear → IDLE with cnt_clr pulse; lap ignored.
- Simultaneous events in the same cycle: priority is clear > start > lap. An event ignored in the current state does not block a lower-priority event.
- Prescaler:
  - Width is $clog2(TICK_DIV).
  - It counts 0..TICK_DIV-1 only in RUN and LAP, wraps to 0, and asserts cnt_en in the cycle its value is TICK_DIV-1.
  - It holds its value in PAUSE, so resume continues the partial period.
  - It is zeroed in IDLE and on every clear.
- The counter's 9999→0000 wrap is owned by the datapath; the controller takes no action on it.
- cnt_en is never asserted in IDLE or PAUSE, and never in the same cycle as cnt_clr.

## Timing
- Reset values: state IDLE, prescaler 0, lap_reg 16'h0000, cnt_en 0, cnt_clr 0, running 0, frozen 0. Debounced levels and synchronizers are 0. disp_bcd = count_in.
- Press latency: raw input rises before edge k and is held stable. The debounced level rises at edge k+1+DEB_CYCLES, the event pulse at edge k+2+DEB_CYCLES, and the state/outputs update at edge k+3+DEB_CYCLES.
- cnt_clr is high exactly one cycle, coincident with the first cycle in the destination state.
- First cnt_en after entering RUN from IDLE occurs TICK_DIV cycles after the state changes.
- lap_reg captures count_in on the same edge that enters LAP. If cnt_en fires on that edge, the pre-increment value is captured.
- RST low mid-operation: all registers return to reset values on the next edge, including mid-debounce counters. A button held through reset must be re-accepted through full debounce.

## Structure
- Shared package chronometer_pkg:
  - State typedef with encoding IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
  - Default constants for TICK_DIV and DEB_CYCLES.
- One sub-module, button_debounce (synchronizer, stability counter, press pulse), instantiated three times.

## Test plan
All scenarios use TICK_DIV=4 and DEB_CYCLES=3.
- Reset then idle 50 cycles → cnt_en, cnt_clr, running, frozen all 0; disp_bcd tracks count_in.
- start press held 10 cycles → running rises 6 cycles after the raw rise; cnt_en pulses every 4 cycles thereafter. A 2-cycle glitch on the button produces no state change.
- In RUN with count_in=16'h0123, press lap → frozen=1 and disp_bcd=16'h0123 while count_in advances. Press lap again → disp_bcd follows count_in.
- start (pause) when prescaler=2, then start (resume) 20 cycles later → first cnt_en arrives 1 cycle after RUN re-entry.
- start and clear pressed in the same cycle while in PAUSE → one-cycle cnt_clr, state IDLE, no RUN. clear in RUN → ignored, cnt_en continues.
- RST low for one cycle during LAP with a button mid-debounce → all outputs return to reset values and lap_reg reads 0. The held button is accepted only after the full debounce.
